// File: rtl/dpll_phase_detector_filter_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
// Shared types and width helpers for the DPLL phase detector / vote filter.
//   filter_state_t : filter FSM states (TRACK, HOLDOFF)
//   vote_t         : per-edge phase decision
//   vote_width     : signed vote counter width for a given threshold
//   timer_width    : width of a down-counter that is loaded with cycles-1
//   count_width    : width of an up-counter that saturates at max_val
// -----------------------------------------------------------------------------
package dpll_pkg;

  typedef enum logic {
    TRACK   = 1'b0,
    HOLDOFF = 1'b1
  } filter_state_t;

  typedef enum logic [1:0] {
    VOTE_NONE  = 2'd0,
    VOTE_EARLY = 2'd1,
    VOTE_LATE  = 2'd2
  } vote_t;

  // One bit of headroom beyond +/-THRESHOLD plus the sign bit.
  function automatic int vote_width(input int threshold);
    return $clog2(threshold) + 2;
  endfunction

  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic int count_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/dpll_phase_detector_filter_if.sv
// -----------------------------------------------------------------------------
// dpll_phase_detector_filter_if
// Signal bundle between the phase detector/filter and its environment.
//   dataSignal_i    : asynchronous incoming data/reference
//   phasedSignal_i  : recovered signal from the phase controller (clk domain)
//   positiveShift_o : one-cycle request, local phase early -> delay it
//   negativeShift_o : one-cycle request, local phase late  -> advance it
//   lock_o          : lock indicator
// master drives the data/phased inputs; slave is the detector itself.
// -----------------------------------------------------------------------------
interface dpll_phase_detector_filter_if;

  logic dataSignal_i;
  logic phasedSignal_i;
  logic positiveShift_o;
  logic negativeShift_o;
  logic lock_o;

  modport master (
    output dataSignal_i,
    output phasedSignal_i,
    input  positiveShift_o,
    input  negativeShift_o,
    input  lock_o
  );

  modport slave (
    input  dataSignal_i,
    input  phasedSignal_i,
    output positiveShift_o,
    output negativeShift_o,
    output lock_o
  );

endinterface

// File: rtl/dpll_phase_detector_filter_edge_sync.sv
// -----------------------------------------------------------------------------
// dpll_edge_sync
// Synchronizes the asynchronous data input and flags every level change as a
// registered one-cycle strobe, together with the new level.
//   clk_i       : system clock
//   reset_i     : asynchronous active-low reset
//   data_async  : asynchronous data input
//   edge_strobe : one-cycle pulse per synchronized level change
//   level       : synchronized level that belongs to the strobe
// -----------------------------------------------------------------------------
module dpll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic data_async,
  output logic edge_strobe,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      edge_strobe <= 1'b0;
      level       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], data_async};
      prev_q      <= sync_q[SYNC_STAGES-1];
      edge_strobe <= sync_q[SYNC_STAGES-1] ^ prev_q;
      level       <= sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/dpll_phase_detector_filter.sv
// -----------------------------------------------------------------------------
// dpll_phase_detector_filter
// Votes early/late on each data edge against the recovered phased signal,
// filters the votes with a random-walk counter and issues one-cycle shift
// requests, followed by a hold-off during which votes are discarded.
//   clk_i   : system clock
//   reset_i : asynchronous active-low reset
//   bus     : slave side of dpll_phase_detector_filter_if
// Build option: DPLL_PHASE_DETECTOR_FILTER_LOCK_DETECT_EN enables the lock
// counter; otherwise lock_o is constant 0.
//
// state   | meaning
// --------+----------------------------------------------------------------
// TRACK   | armed edges vote; counter walks toward +/-THRESHOLD
// HOLDOFF | oscillator settling after a shift; edges discarded, counter 0
// -----------------------------------------------------------------------------
module dpll_phase_detector_filter
  import dpll_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int THRESHOLD      = 8,
  parameter int HOLDOFF_CYCLES = 128,
  parameter int LOCK_EDGES     = 32
) (
  input logic                          clk_i,
  input logic                          reset_i,
  dpll_phase_detector_filter_if.slave  bus
);

  localparam int VW = vote_width(THRESHOLD);
  localparam int TW = timer_width(HOLDOFF_CYCLES);

  localparam logic signed [VW-1:0] THR_POS   = VW'(THRESHOLD);
  localparam logic signed [VW-1:0] THR_NEG   = -THR_POS;
  localparam logic signed [VW-1:0] ONE       = VW'(1);
  localparam logic        [TW-1:0] HOLD_LOAD = TW'(HOLDOFF_CYCLES - 1);

  if (SYNC_STAGES < 2 || THRESHOLD < 2 || HOLDOFF_CYCLES < 1 || LOCK_EDGES < 1) begin : g_param_check
    $error("dpll_phase_detector_filter: parameter out of range");
  end

  logic                 edge_strobe;
  logic                 level;
  logic                 armed_q;
  vote_t                vote;
  logic signed [VW-1:0] vote_sum;

  filter_state_t        state_q, state_d;
  logic signed [VW-1:0] cnt_q, cnt_d;
  logic        [TW-1:0] timer_q, timer_d;
  logic                 pos_q, pos_d;
  logic                 neg_q, neg_d;

  dpll_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_async  (bus.dataSignal_i),
    .edge_strobe (edge_strobe),
    .level       (level)
  );

  // The first strobe after reset only arms; with data high at reset release
  // that strobe comes from the synchronizer filling, not from a real edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)         armed_q <= 1'b0;
    else if (edge_strobe) armed_q <= 1'b1;
  end

  always_comb begin
    vote = VOTE_NONE;
    if (edge_strobe && armed_q)
      vote = (bus.phasedSignal_i == level) ? VOTE_EARLY : VOTE_LATE;
  end

  always_comb begin
    case (vote)
      VOTE_EARLY: vote_sum = cnt_q + ONE;
      VOTE_LATE:  vote_sum = cnt_q - ONE;
      default:    vote_sum = cnt_q;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= TRACK;
      cnt_q   <= '0;
      timer_q <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    case (state_q)
      TRACK: begin
        if (vote != VOTE_NONE) begin
          if (vote_sum == THR_POS || vote_sum == THR_NEG) begin
            cnt_d   = '0;
            pos_d   = (vote_sum == THR_POS);
            neg_d   = (vote_sum == THR_NEG);
            state_d = HOLDOFF;
            timer_d = HOLD_LOAD;
          end else begin
            cnt_d = vote_sum;
          end
        end
      end
      HOLDOFF: begin
        cnt_d = '0;
        if (timer_q == '0) state_d = TRACK;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = TRACK;
    endcase
  end

  // Outputs
  always_comb begin
    bus.positiveShift_o = pos_q;
    bus.negativeShift_o = neg_q;
  end

`ifdef DPLL_PHASE_DETECTOR_FILTER_LOCK_DETECT_EN
  localparam int LW = count_width(LOCK_EDGES);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_EDGES);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_q;

  // A shift clears the count even when the deciding vote would have counted.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (pos_d || neg_d)
      lock_cnt_d = '0;
    else if (state_q == TRACK && vote != VOTE_NONE && lock_cnt_q != LOCK_MAX)
      lock_cnt_d = lock_cnt_q + LW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= (lock_cnt_d == LOCK_MAX);
    end
  end

  assign bus.lock_o = lock_q;
`else
  assign bus.lock_o = 1'b0;
`endif

endmodule
